// File: rtl/sig_drv_pkg.sv
// Shared types for the signal-processing host driver: FSM states, sample source
// encodings, LFSR taps and the sample-advance helper.
package sig_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_FINISH
  } drv_state_e;

  typedef enum logic {
    SRC_RAMP = 1'b0,
    SRC_LFSR = 1'b1
  } src_sel_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Galois right-shift LFSR or wrapping ramp.
  function automatic logic [15:0] next_sample(input logic [15:0] s, input src_sel_e sel);
    if (sel == SRC_LFSR) begin
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    end
    return s + 16'd1;
  endfunction

endpackage

// File: rtl/sig_drv_fifo.sv
// Show-ahead capture FIFO (DEPTH x WIDTH, DEPTH a power of 2) with full/empty/count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sig_drv_fifo
  import sig_drv_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sig_proc_driver.sv
// Burst stimulus generator and result capture for the signal-processing host.
// Optional result checksum enabled by defining SIG_DRV_CHECKSUM_EN.
module sig_proc_driver
  import sig_drv_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CAP_DEPTH      = 8,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        src_sel,
  input  logic [1:0]  cfg_mode,
  output logic [15:0] drv_signal,
  output logic        drv_enable,
  output logic [1:0]  drv_mode,
  input  logic        host_done,
  input  logic [15:0] host_result,
  output logic [15:0] cap_data,
  output logic        cap_valid,
  input  logic        cap_ready,
  output logic        busy,
  output logic        burst_done,
  output logic        timeout_err,
  output logic [7:0]  sample_count,
  output logic [15:0] chk_sum
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CW = $clog2(CAP_DEPTH) + 1;

  drv_state_e  state_q, state_d;
  logic [15:0] sample_q, sample_d;
  src_sel_e    src_q, src_d;
  logic [1:0]  mode_q, mode_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]  scnt_q, scnt_d;
  logic        terr_q, terr_d;
  logic        drv_en;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign fifo_pop  = !fifo_empty && cap_ready;
  // A pop in the same cycle frees the slot, so a full FIFO only stalls without one.
  assign fifo_push = (state_q == ST_CAPTURE) && (!fifo_full || fifo_pop);

  sig_drv_fifo #(
    .DEPTH (CAP_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (host_result),
    .pop_i   (fifo_pop),
    .rdata_o (cap_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    src_d    = src_q;
    mode_d   = mode_q;
    tmo_d    = tmo_q;
    scnt_d   = scnt_q;
    terr_d   = terr_q;
    drv_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d    = src_sel_e'(src_sel);
          mode_d   = cfg_mode;
          sample_d = SEED;
          scnt_d   = '0;
          terr_d   = 1'b0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        drv_en  = 1'b1;
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        drv_en = 1'b1;
        tmo_d  = tmo_q + TW'(1);
        if (host_done) begin
          state_d = ST_CAPTURE;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          terr_d  = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_CAPTURE: begin
        if (fifo_push) begin
          drv_en   = 1'b1;
          scnt_d   = scnt_q + 8'd1;
          sample_d = next_sample(sample_q, src_q);
          state_d  = (scnt_q == 8'(NUM_SAMPLES - 1)) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      src_q    <= SRC_RAMP;
      mode_q   <= '0;
      tmo_q    <= '0;
      scnt_q   <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      src_q    <= src_d;
      mode_q   <= mode_d;
      tmo_q    <= tmo_d;
      scnt_q   <= scnt_d;
      terr_q   <= terr_d;
    end
  end

`ifdef SIG_DRV_CHECKSUM_EN
  logic [15:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (state_q == ST_IDLE && start) begin
      chk_d = '0;
    end else if (fifo_push) begin
      chk_d = {chk_q[14:0], chk_q[15]} ^ host_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign chk_sum = chk_q;
`else
  assign chk_sum = '0;
`endif

  assign drv_signal   = sample_q;
  assign drv_enable   = drv_en;
  assign drv_mode     = mode_q;
  assign cap_valid    = !fifo_empty;
  assign busy         = (state_q != ST_IDLE);
  assign burst_done   = (state_q == ST_FINISH);
  assign timeout_err  = terr_q;
  assign sample_count = scnt_q;

  a_fifo_full_count: assert property (@(posedge clk) disable iff (rst)
    fifo_full == (fifo_count == CW'(CAP_DEPTH)));

endmodule

// File: tb/tb_sig_proc_driver.sv
// Randomised bench for sig_proc_driver: host responder, show-ahead drain and a
// sample/result/checksum reference model computed from the burst rules.
module tb_sig_proc_driver;

  localparam int unsigned NS    = 4;
  localparam int unsigned TMO   = 24;
  localparam int unsigned DEPTH = 2;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        src_sel = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic        host_done = 1'b0;
  logic [15:0] host_result = 16'h0000;
  logic        cap_ready = 1'b0;
  logic [15:0] drv_signal, cap_data, chk_sum;
  logic        drv_enable, cap_valid, busy, burst_done, timeout_err;
  logic [1:0]  drv_mode;
  logic [7:0]  sample_count;

  sig_proc_driver #(
    .NUM_SAMPLES    (NS),
    .TIMEOUT_CYCLES (TMO),
    .CAP_DEPTH      (DEPTH),
    .SEED           (SEED)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .src_sel      (src_sel),
    .cfg_mode     (cfg_mode),
    .drv_signal   (drv_signal),
    .drv_enable   (drv_enable),
    .drv_mode     (drv_mode),
    .host_done    (host_done),
    .host_result  (host_result),
    .cap_data     (cap_data),
    .cap_valid    (cap_valid),
    .cap_ready    (cap_ready),
    .busy         (busy),
    .burst_done   (burst_done),
    .timeout_err  (timeout_err),
    .sample_count (sample_count),
    .chk_sum      (chk_sum)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0] exp_sig [NS];
  logic [15:0] exp_res [NS];
  logic [15:0] exp_chk [NS+1];
  logic [15:0] exp_q [$];
  logic [1:0]  exp_mode;

  int unsigned issue_idx = 0;
  bit          served_valid = 1'b0;
  logic [15:0] served = 16'h0000;
  bit          host_mute = 1'b0;
  bit          host_pend = 1'b0;
  int unsigned host_cnt = 0;
  logic [15:0] host_val = 16'h0000;
  int unsigned ready_pct = 100;
  bit          one_pop = 1'b0;
  int unsigned cyc = 0;
  int unsigned issue_cyc = 0;
  int unsigned done_cyc = 0;
  int unsigned bd_cnt = 0;

  function automatic logic [15:0] model_next(input logic [15:0] s, input bit lfsr);
    if (lfsr) return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    return s + 16'd1;
  endfunction

  function automatic logic [15:0] chk_exp(input int unsigned i);
`ifdef SIG_DRV_CHECKSUM_EN
    return exp_chk[i];
`else
    return 16'h0000 & exp_chk[i];
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Host responder and per-issue monitor
  always @(negedge clk) begin
    host_done = 1'b0;
    if (rst) begin
      host_pend = 1'b0;
    end else begin
      if (host_pend) begin
        if (host_cnt <= 1) begin
          host_done   = 1'b1;
          host_result = host_val;
          host_pend   = 1'b0;
        end else begin
          host_cnt--;
        end
      end
      if (drv_enable && (!served_valid || drv_signal != served)) begin
        served       = drv_signal;
        served_valid = 1'b1;
        issue_cyc    = cyc;
        if (issue_idx < NS) begin
          check("issue_signal", drv_signal, exp_sig[issue_idx]);
          check("issue_mode", drv_mode, exp_mode);
          check("issue_count", sample_count, issue_idx);
          check("issue_chk", chk_sum, chk_exp(issue_idx));
          check("issue_busy", busy, 1);
          check("issue_terr", timeout_err, 0);
          host_val = exp_res[issue_idx];
        end
        issue_idx++;
        if (!host_mute) begin
          host_pend = 1'b1;
          host_cnt  = $urandom_range(1, 4);
        end
      end
      if (burst_done) begin
        bd_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Downstream drain with randomised ready
  always @(negedge clk) begin
    if (one_pop && cap_valid) begin
      cap_ready = 1'b1;
      one_pop   = 1'b0;
    end else begin
      cap_ready = ($urandom_range(0, 99) < ready_pct);
    end
    if (!rst && cap_ready && cap_valid) begin
      if (exp_q.size() == 0) check("fifo_extra_pop", exp_q.size(), 1);
      else                   check("fifo_pop", cap_data, exp_q.pop_front());
    end
  end

  task automatic launch(input bit src, input logic [1:0] mode, input logic [15:0] key,
                        input bit use_tab, input bit mute);
    logic [15:0] tab [NS];
    logic [15:0] s;
    logic [15:0] c;
    tab = '{16'h0001, 16'h0004, 16'h0010, 16'h0040};
    s = SEED;
    c = 16'h0000;
    for (int i = 0; i < NS; i++) begin
      exp_sig[i] = s;
      exp_res[i] = use_tab ? tab[i] : (s ^ key);
      exp_chk[i] = c;
      c = {c[14:0], c[15]} ^ exp_res[i];
      s = model_next(s, src);
      if (!mute) exp_q.push_back(exp_res[i]);
    end
    exp_chk[NS]  = c;
    exp_mode     = mode;
    host_mute    = mute;
    issue_idx    = 0;
    served_valid = 1'b0;
    bd_cnt       = 0;
    @(negedge clk);
    start    = 1'b1;
    src_sel  = src;
    cfg_mode = mode;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_issue(input int unsigned n, input string tag);
    for (int i = 0; i < 500; i++) begin
      if (issue_idx >= n) break;
      @(negedge clk);
    end
    check(tag, (issue_idx >= n), 1);
  endtask

  task automatic wait_burst(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (bd_cnt != 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check(tag, bd_cnt, 1);
    check("idle_busy", busy, 0);
    check("idle_mode", drv_mode, exp_mode);
  endtask

  task automatic post_ok();
    check("end_count", sample_count, NS);
    check("end_terr", timeout_err, 0);
    check("end_issues", issue_idx, NS);
    check("end_chk", chk_sum, chk_exp(NS));
  endtask

  task automatic drain();
    ready_pct = 100;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
    check("drain_valid", cap_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_signal"}, drv_signal, 0);
    check({tag, "_enable"}, drv_enable, 0);
    check({tag, "_mode"}, drv_mode, 0);
    check({tag, "_valid"}, cap_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, burst_done, 0);
    check({tag, "_terr"}, timeout_err, 0);
    check({tag, "_count"}, sample_count, 0);
    check({tag, "_chk"}, chk_sum, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    // Ramp burst with result = sample ^ 00FF
    ready_pct = 100;
    launch(1'b0, 2'd1, 16'h00FF, 1'b0, 1'b0);
    wait_burst("ramp_done");
    post_ok();
    drain();

    // LFSR burst in mode 2
    launch(1'b1, 2'd2, 16'($urandom), 1'b0, 1'b0);
    wait_burst("lfsr_done");
    post_ok();
    drain();

    // Fixed results for the rotate/xor checksum
    launch(1'b0, 2'd3, 16'h0000, 1'b1, 1'b0);
    wait_burst("chk_done");
    post_ok();
    drain();

    // Capture stall with the downstream blocked
    ready_pct = 0;
    launch(1'b0, 2'd0, 16'($urandom), 1'b0, 1'b0);
    wait_issue(3, "stall_issue3");
    repeat (10) @(negedge clk);
    check("stall1_enable", drv_enable, 0);
    check("stall1_count", sample_count, 2);
    check("stall1_busy", busy, 1);
    check("stall1_valid", cap_valid, 1);
    one_pop = 1'b1;
    wait_issue(4, "stall_issue4");
    repeat (10) @(negedge clk);
    check("stall2_enable", drv_enable, 0);
    check("stall2_count", sample_count, 3);
    ready_pct = 100;
    wait_burst("stall_done");
    post_ok();
    drain();

    // Host never answers
    launch(1'($urandom), 2'($urandom), 16'h0000, 1'b0, 1'b1);
    wait_burst("tmo_done");
    check("tmo_latency", done_cyc - issue_cyc, TMO + 1);
    check("tmo_terr", timeout_err, 1);
    check("tmo_count", sample_count, 0);
    check("tmo_valid", cap_valid, 0);
    host_mute = 1'b0;

    // Reset during WAIT, then a clean burst
    launch(1'b0, 2'd2, 16'($urandom), 1'b0, 1'b0);
    wait_issue(1, "rstw_issue");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rstw");
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    launch(1'b0, 2'd1, 16'($urandom), 1'b0, 1'b0);
    wait_burst("rstw_after");
    post_ok();
    drain();

    // Random bursts; results left in the FIFO carry over between bursts
    for (int b = 0; b < 8; b++) begin
      ready_pct = $urandom_range(20, 100);
      launch(1'($urandom), 2'($urandom), 16'($urandom), 1'b0, 1'b0);
      if (b % 2 == 0) begin
        wait_issue(2, "rnd_issue2");
        @(negedge clk);
        start    = 1'b1;
        src_sel  = ~src_sel;
        cfg_mode = ~cfg_mode;
        @(negedge clk);
        start = 1'b0;
      end
      wait_burst("rnd_done");
      post_ok();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
